// File: rtl/uart_retrans_rx_p.sv
// ---------------------------------------------------------------------------
// uart_retrans_rx_p
//   Serial receiver with built-in retransmission control. The line carries one
//   bit per clock: start (0), DATA_W data bits LSB first, an optional parity
//   bit, and a stop bit (1). Good frames are presented on data/valid and held
//   until ack. A bad frame, or no start bit within TIMEOUT cycles after a
//   resend request, pulses request_resend and bumps resend_count. Once
//   MAX_RETRY requests have been spent, the next failure raises a sticky
//   error instead. The error is cleared by ack.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high reset
//   signal         : serial line, idle high
//   ack            : consumer accepts data (HOLD) or clears error (FAIL)
//   data           : last good word received
//   valid          : data holds a good frame, held until ack
//   error          : retry budget exhausted, sticky until ack
//   request_resend : one-cycle pulse asking the sender to retransmit
//   resend_count   : resend requests issued for the current word
// ---------------------------------------------------------------------------
module uart_retrans_rx_p #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int TIMEOUT    = 8,
  parameter int MAX_RETRY  = 4,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              signal,
  input  logic              ack,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              error,
  output logic              request_resend,
  output logic [CNT_W-1:0]  resend_count
);

  localparam int FRAME_L = DATA_W + 2 + PARITY_EN;
  localparam int BIT_W   = $clog2(FRAME_L);
  localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // bit_cnt indexes the bits after the start bit; the stop bit is the last one
  localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(FRAME_L - 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RETRY);

  // The good/bad verdict is taken on the edge that samples the stop bit (or
  // on the timeout edge). Its effects are registered directly, so HOLD,
  // WAIT and FAIL are the only states that follow a verdict.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    HOLD = 3'd2,
    WAIT = 3'd3,
    FAIL = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic [TMR_W-1:0]    timer, timer_nx;
  logic [DATA_W-1:0]   data_nx;
  logic                valid_nx, error_nx, req_nx;
  logic [CNT_W-1:0]    cnt_nx;
  logic                frame_bad;

  logic [DATA_W-1:0]   shreg;
  logic                par_acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c < CNT_MAX) ? c + 1'b1 : c;
  endfunction

  // acc is the XOR of all data bits and the parity bit
  function automatic logic parity_ok(input logic acc);
    if (PARITY_EN == 0) return 1'b1;
    return acc == (PARITY_ODD != 0);
  endfunction

  // ---- stage: line sampling (data bits and running parity) ----
  always_ff @(posedge clk) begin
    if (state == RECV) begin
      // each data bit lands at its own index, so no shift chain depends on DATA_W
      for (int i = 0; i < DATA_W; i++) begin
        if (bit_cnt == BIT_W'(i)) shreg[i] <= signal;
      end
    end
    // cleared in every non-RECV cycle, which always precedes a frame
    par_acc <= (state == RECV) ? (par_acc ^ signal) : 1'b0;
  end

  // ---- stage: control next-state ----
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    timer_nx   = timer;
    data_nx    = data;
    valid_nx   = valid;
    error_nx   = error;
    req_nx     = 1'b0;
    cnt_nx     = resend_count;
    frame_bad  = 1'b0;

    case (state)
      IDLE: begin
        if (!signal) begin
          state_nx   = RECV;
          bit_cnt_nx = '0;
        end
      end
      RECV: begin
        if (bit_cnt == STOP_IDX) begin
          if (signal && parity_ok(par_acc)) begin
            state_nx = HOLD;
            valid_nx = 1'b1;
            data_nx  = shreg;
          end else begin
            frame_bad = 1'b1;
          end
        end else begin
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          valid_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      WAIT: begin
        // a start bit in the expiry cycle still wins
        if (!signal) begin
          state_nx   = RECV;
          bit_cnt_nx = '0;
        end else if (timer == TMR_LAST) begin
          frame_bad = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      FAIL: begin
        if (ack) begin
          error_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (frame_bad) begin
      if (resend_count < CNT_MAX) begin
        req_nx   = 1'b1;
        cnt_nx   = sat_inc(resend_count);
        state_nx = WAIT;
        timer_nx = '0;
      end else begin
        error_nx = 1'b1;
        state_nx = FAIL;
      end
    end
  end

  // ---- stage: registered control and outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      timer          <= '0;
      data           <= '0;
      valid          <= 1'b0;
      error          <= 1'b0;
      request_resend <= 1'b0;
      resend_count   <= '0;
    end else begin
      state          <= state_nx;
      bit_cnt        <= bit_cnt_nx;
      timer          <= timer_nx;
      data           <= data_nx;
      valid          <= valid_nx;
      error          <= error_nx;
      request_resend <= req_nx;
      resend_count   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_uart_retrans_rx_p.sv
// ---------------------------------------------------------------------------
// tb_uart_retrans_rx_p
//   Bench for uart_retrans_rx_p with three parameterisations:
//     lane A: DATA_W=8, even parity (TIMEOUT=8, MAX_RETRY=4)
//     lane B: DATA_W=16, no parity (PARITY_ODD=1 must be ignored)
//     lane C: DATA_W=8, odd parity
//   Lane A is driven by directed and random transactions whose outcome is
//   predicted from the frame rules (parity, stop bit, retry budget, timeout).
// ---------------------------------------------------------------------------
module tb_uart_retrans_rx_p;

  localparam int TO = 8;
  localparam int MR = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        sig_a = 1'b1, ack_a = 1'b0;
  logic [7:0]  data_a;
  logic        valid_a, error_a, req_a;
  logic [4:0]  cnt_a;

  logic        sig_b = 1'b1, ack_b = 1'b0;
  logic [15:0] data_b;
  logic        valid_b, error_b, req_b;
  logic [4:0]  cnt_b;

  logic        sig_c = 1'b1, ack_c = 1'b0;
  logic [7:0]  data_c;
  logic        valid_c, error_c, req_c;
  logic [4:0]  cnt_c;

  uart_retrans_rx_p #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .TIMEOUT(TO),
                      .MAX_RETRY(MR), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset), .signal(sig_a), .ack(ack_a), .data(data_a),
    .valid(valid_a), .error(error_a), .request_resend(req_a), .resend_count(cnt_a));

  uart_retrans_rx_p #(.DATA_W(16), .PARITY_EN(0), .PARITY_ODD(1), .TIMEOUT(TO),
                      .MAX_RETRY(MR), .CNT_W(5)) dut_b (
    .clk(clk), .reset(reset), .signal(sig_b), .ack(ack_b), .data(data_b),
    .valid(valid_b), .error(error_b), .request_resend(req_b), .resend_count(cnt_b));

  uart_retrans_rx_p #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .TIMEOUT(TO),
                      .MAX_RETRY(MR), .CNT_W(5)) dut_c (
    .clk(clk), .reset(reset), .signal(sig_c), .ack(ack_c), .data(data_c),
    .valid(valid_c), .error(error_c), .request_resend(req_c), .resend_count(cnt_c));

  int errors = 0;
  int checks = 0;

  // reference state of lane A
  int m_cnt     = 0;  // resend requests issued for the current word
  bit m_wait    = 0;  // waiting for a retransmission
  int m_elapsed = 0;  // idle cycles already spent in the current wait
  bit m_fail    = 0;  // retry budget exhausted

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sig(input int lane, input logic v);
    case (lane)
      0: sig_a = v;
      1: sig_b = v;
      default: sig_c = v;
    endcase
  endtask

  function automatic logic lane_valid(input int lane);
    case (lane)
      0: return valid_a;
      1: return valid_b;
      default: return valid_c;
    endcase
  endfunction

  // Drives one whole frame; returns #1 after the edge that sampled the stop bit.
  task automatic send(input int lane, input logic [31:0] word, input int dw,
                      input bit pen, input bit podd, input bit flip_par, input bit stop_bit);
    logic p;
    set_sig(lane, 1'b0);
    tick();
    for (int i = 0; i < dw; i++) begin
      set_sig(lane, word[i]);
      tick();
    end
    if (pen) begin
      p = podd;
      for (int i = 0; i < dw; i++) p = p ^ word[i];
      if (flip_par) p = ~p;
      set_sig(lane, p);
      tick();
    end
    set_sig(lane, stop_bit);
    chk("valid_before_stop_edge", 64'(lane_valid(lane)), 64'(0));
    tick();
    set_sig(lane, 1'b1);
  endtask

  task automatic outcome_good(input logic [7:0] w);
    int hold;
    chk("good_valid", 64'(valid_a), 64'(1));
    chk("good_data", 64'(data_a), 64'(w));
    chk("good_req", 64'(req_a), 64'(0));
    chk("good_error", 64'(error_a), 64'(0));
    chk("good_cnt", 64'(cnt_a), 64'(m_cnt));
    hold = $urandom_range(0, 5);
    repeat (hold) begin
      sig_a = 1'($urandom_range(0, 1));
      tick();
    end
    sig_a = 1'b1;
    chk("hold_valid", 64'(valid_a), 64'(1));
    chk("hold_data", 64'(data_a), 64'(w));
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    chk("ack_valid", 64'(valid_a), 64'(0));
    chk("ack_cnt", 64'(cnt_a), 64'(0));
    m_cnt  = 0;
    m_wait = 0;
  endtask

  task automatic outcome_bad();
    if (m_cnt < MR) begin
      chk("bad_req", 64'(req_a), 64'(1));
      chk("bad_cnt", 64'(cnt_a), 64'(m_cnt + 1));
      chk("bad_valid", 64'(valid_a), 64'(0));
      chk("bad_error", 64'(error_a), 64'(0));
      m_cnt++;
      m_wait = 1;
      tick();
      chk("req_one_cycle", 64'(req_a), 64'(0));
      m_elapsed = 1;
    end else begin
      chk("exhaust_error", 64'(error_a), 64'(1));
      chk("exhaust_req", 64'(req_a), 64'(0));
      chk("exhaust_cnt", 64'(cnt_a), 64'(MR));
      chk("exhaust_valid", 64'(valid_a), 64'(0));
      m_fail = 1;
      m_wait = 0;
    end
  endtask

  task automatic fail_clear();
    int n;
    n = $urandom_range(0, 3);
    repeat (n) begin
      sig_a = 1'($urandom_range(0, 1));
      tick();
    end
    sig_a = 1'b1;
    chk("fail_sticky", 64'(error_a), 64'(1));
    chk("fail_no_valid", 64'(valid_a), 64'(0));
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    chk("fail_ack_error", 64'(error_a), 64'(0));
    chk("fail_ack_cnt", 64'(cnt_a), 64'(0));
    m_fail = 0;
    m_cnt  = 0;
  endtask

  // kind: 0 good frame, 1 parity flipped, 2 stop bit 0, 3 no frame (idle / timeout)
  task automatic txn_a(input int kind, input logic [7:0] w, input int gap);
    int g;
    if (m_fail) begin
      fail_clear();
      return;
    end
    if (kind == 3) begin
      if (!m_wait) begin
        repeat (gap + 1) begin
          ack_a = 1'($urandom_range(0, 1));
          tick();
        end
        ack_a = 1'b0;
        chk("idle_valid", 64'(valid_a), 64'(0));
        chk("idle_req", 64'(req_a), 64'(0));
        chk("idle_error", 64'(error_a), 64'(0));
        chk("idle_cnt", 64'(cnt_a), 64'(m_cnt));
      end else begin
        repeat (TO - m_elapsed - 1) tick();
        chk("pre_timeout_req", 64'(req_a), 64'(0));
        tick();
        outcome_bad();
      end
      return;
    end
    g = gap;
    if (m_wait && g > TO - 1 - m_elapsed) g = TO - 1 - m_elapsed;
    repeat (g) tick();
    send(0, 32'(w), 8, 1'b1, 1'b0, kind == 1, kind != 2);
    if (kind == 0) outcome_good(w);
    else outcome_bad();
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_wait = 0;
    m_elapsed = 0;
    m_fail = 0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_valid"}, 64'(valid_a), 64'(0));
    chk({tag, "_data"}, 64'(data_a), 64'(0));
    chk({tag, "_error"}, 64'(error_a), 64'(0));
    chk({tag, "_req"}, 64'(req_a), 64'(0));
    chk({tag, "_cnt"}, 64'(cnt_a), 64'(0));
    sig_a = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    tick();
  endtask

  initial begin
    logic [15:0] wb;
    // power-up reset
    #2 reset = 1'b1;
    #2;
    chk("rst_valid", 64'(valid_a), 64'(0));
    chk("rst_data", 64'(data_a), 64'(0));
    chk("rst_cnt", 64'(cnt_a), 64'(0));
    tick();
    tick();
    #3 reset = 1'b0;
    tick();

    // lane B: 16-bit, no parity bit, valid L=17 cycles after the start bit
    send(1, 32'h1234, 16, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("b_valid", 64'(valid_b), 64'(1));
    chk("b_data", 64'(data_b), 64'(16'h1234));
    ack_b = 1'b1; tick(); ack_b = 1'b0;
    chk("b_ack_valid", 64'(valid_b), 64'(0));
    for (int k = 0; k < 4; k++) begin
      wb = 16'($urandom);
      send(1, 32'(wb), 16, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("b_rand_data", 64'(data_b), 64'(wb));
      chk("b_rand_valid", 64'(valid_b), 64'(1));
      ack_b = 1'b1; tick(); ack_b = 1'b0;
    end

    // lane C: odd parity, 0x00 needs parity 1
    send(2, 32'h00, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("c_odd_valid", 64'(valid_c), 64'(1));
    chk("c_odd_req", 64'(req_c), 64'(0));
    ack_c = 1'b1; tick(); ack_c = 1'b0;
    send(2, 32'h00, 8, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("c_even_par_req", 64'(req_c), 64'(1));
    chk("c_even_par_cnt", 64'(cnt_c), 64'(1));
    chk("c_even_par_valid", 64'(valid_c), 64'(0));

    // lane A directed
    txn_a(3, 8'h00, 3);
    txn_a(0, 8'hA5, 0);
    txn_a(1, 8'hA5, 0);
    txn_a(0, 8'hA5, 2);
    txn_a(1, 8'h3C, 0);
    txn_a(3, 8'h00, 0);
    txn_a(3, 8'h00, 0);
    txn_a(3, 8'h00, 0);
    txn_a(3, 8'h00, 0);
    txn_a(0, 8'h00, 0);
    txn_a(2, 8'h5A, 0);
    txn_a(0, 8'h5A, 99);

    // async reset mid-RECV with a nonzero retry count
    txn_a(1, 8'h77, 0);
    sig_a = 1'b0; tick();
    sig_a = 1'b1; tick();
    sig_a = 1'b0; tick();
    async_reset_check("rst_recv");
    txn_a(0, 8'hC3, 1);

    // async reset during HOLD
    send(0, 32'h96, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_hold_valid", 64'(valid_a), 64'(1));
    tick();
    async_reset_check("rst_hold");
    txn_a(0, 8'h3E, 0);

    // lane A random
    for (int k = 0; k < 80; k++) begin
      txn_a(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 9)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
